// File: rtl/dfa_state_pkg.sv
// DFA state RMW arbiter shared types.
// FSM encoding and counter width.
package dfa_state_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } fsm_state_t;

  localparam int RMW_COUNT_WIDTH = 16;

endpackage

// File: rtl/dfa_state_rmw_arbiter_rr_arbiter.sv
// One-hot round-robin arbiter.
// Search starts at the pointer; pointer moves past the winner.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_any
);

  logic [IW-1:0] ptr_q;
  int            c;

  // first requester at or after the pointer wins
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    c       = 0;
    if (en) begin
      for (int k = 0; k < N; k++) begin
        c = (int'(ptr_q) + k) % N;
        if (!gnt_any && req[c]) begin
          gnt_any = 1'b1;
          gnt[c]  = 1'b1;
          gnt_idx = IW'(c);
        end
      end
    end
  end

  // pointer advances to the slot after the winner
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (gnt_any) begin
      if (gnt_idx == IW'(N - 1))
        ptr_q <= '0;
      else
        ptr_q <= gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/dfa_state_rmw_arbiter.sv
// Round-robin RMW scheduler over one DFA state RAM.
// Stage 0 reads, stage 1 responds and writes back.
module dfa_state_rmw_arbiter
  import dfa_state_pkg::*;
#(
  parameter int NUM_CLIENTS   = 4,
  parameter int ADDRESS_WIDTH = 4,
  parameter int DATA_WIDTH    = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_CLIENTS-1:0] req_valid,
  input  logic [NUM_CLIENTS*ADDRESS_WIDTH-1:0] req_address,
  output logic [NUM_CLIENTS-1:0] req_ready,
  output logic [NUM_CLIENTS-1:0] rsp_valid,
  output logic [DATA_WIDTH-1:0]  rsp_state,
  input  logic [NUM_CLIENTS-1:0] upd_write,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] upd_writedata,
  output logic [ADDRESS_WIDTH-1:0] mem_rd_address,
  input  logic [DATA_WIDTH-1:0]    mem_rd_readdata,
  output logic [ADDRESS_WIDTH-1:0] mem_wr_address,
  output logic [DATA_WIDTH-1:0]    mem_wr_writedata,
  output logic                     mem_wr_write,
  input  logic                     mem_wr_waitrequest,
  output logic                     busy,
  output logic [RMW_COUNT_WIDTH-1:0] rmw_count
);

  localparam int AW = ADDRESS_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int IW =
    (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

  fsm_state_t state_q;
  fsm_state_t state_d;

  logic          arb_en;
  logic          gnt_any;
  logic [IW-1:0] gnt_idx;
  logic [AW-1:0] win_address;
  logic [AW-1:0] rd_address_q;

  logic          s1_valid_q;
  logic [IW-1:0] s1_client_q;
  logic [AW-1:0] s1_address_q;
  logic          s1_live;
  logic          s1_write;

  logic [RMW_COUNT_WIDTH-1:0] count_q;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset)
      state_q <= INIT;
    else
      state_q <= state_d;
  end

  // RAM readiness tracking; arbitrate only in RUN
  always_comb begin
    state_d = state_q;
    arb_en  = 1'b0;
    unique case (state_q)
      INIT: begin
        if (!mem_wr_waitrequest)
          state_d = RUN;
      end
      RUN: begin
        if (mem_wr_waitrequest)
          state_d = INIT;
        else
          arb_en = 1'b1;
      end
    endcase
  end

  rr_arbiter #(
    .N  (NUM_CLIENTS),
    .IW (IW)
  ) u_arb (
    .clk     (clk),
    .reset   (reset),
    .en      (arb_en),
    .req     (req_valid),
    .gnt     (req_ready),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // stage 0: winner's address to the read port, else hold
  always_comb begin
    win_address =
      req_address[int'(gnt_idx)*AW +: AW];
    if (gnt_any)
      mem_rd_address = win_address;
    else
      mem_rd_address = rd_address_q;
  end

  // stage 0 -> stage 1 pipeline register
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_address_q <= '0;
      s1_valid_q   <= 1'b0;
      s1_client_q  <= '0;
      s1_address_q <= '0;
    end else begin
      rd_address_q <= mem_rd_address;
      s1_valid_q   <= gnt_any;
      if (gnt_any) begin
        s1_client_q  <= gnt_idx;
        s1_address_q <= win_address;
      end
    end
  end

  // stage 1: respond and write back unless RAM or reset aborts
  always_comb begin
    s1_live  = s1_valid_q
             && !mem_wr_waitrequest
             && !reset;
    s1_write = s1_live
             && upd_write[s1_client_q];
    rsp_valid = '0;
    rsp_state = '0;
    mem_wr_write     = s1_write;
    mem_wr_address   = '0;
    mem_wr_writedata = '0;
    if (s1_live) begin
      rsp_valid[s1_client_q] = 1'b1;
      rsp_state = mem_rd_readdata;
    end
    if (s1_write) begin
      mem_wr_address   = s1_address_q;
      mem_wr_writedata =
        upd_writedata[int'(s1_client_q)*DW +: DW];
    end
  end

  // saturating count of completed RMWs
  always_ff @(posedge clk) begin
    if (reset)
      count_q <= '0;
    else if (s1_live && count_q != '1)
      count_q <= count_q + 1'b1;
  end

  assign rmw_count = count_q;
  assign busy = (state_q == INIT) || s1_valid_q;

endmodule

// File: tb/tb_dfa_state_rmw_arbiter.sv
// Directed bench for dfa_state_rmw_arbiter.
// RAM model with bypass; response scoreboard queue.
module tb_dfa_state_rmw_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [15:0] req_address;
  logic [3:0]  req_ready;
  logic [3:0]  rsp_valid;
  logic [1:0]  rsp_state;
  logic [3:0]  upd_write;
  logic [7:0]  upd_writedata;
  logic [3:0]  mem_rd_address;
  logic [1:0]  mem_rd_readdata;
  logic [3:0]  mem_wr_address;
  logic [1:0]  mem_wr_writedata;
  logic        mem_wr_write;
  logic        mem_wr_waitrequest;
  logic        busy;
  logic [15:0] rmw_count;

  typedef struct {
    int         client;
    logic [3:0] addr;
    logic [1:0] state;
  } rsp_t;

  rsp_t        pend[$];
  logic [1:0]  exp_mem [16];
  logic [1:0]  ram [16];
  logic [15:0] exp_cnt;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  dfa_state_rmw_arbiter dut (
    .clk                (clk),
    .reset              (reset),
    .req_valid          (req_valid),
    .req_address        (req_address),
    .req_ready          (req_ready),
    .rsp_valid          (rsp_valid),
    .rsp_state          (rsp_state),
    .upd_write          (upd_write),
    .upd_writedata      (upd_writedata),
    .mem_rd_address     (mem_rd_address),
    .mem_rd_readdata    (mem_rd_readdata),
    .mem_wr_address     (mem_wr_address),
    .mem_wr_writedata   (mem_wr_writedata),
    .mem_wr_write       (mem_wr_write),
    .mem_wr_waitrequest (mem_wr_waitrequest),
    .busy               (busy),
    .rmw_count          (rmw_count)
  );

  // state RAM: clears while waitrequest, write bypass on read
  always_ff @(posedge clk) begin
    if (mem_wr_waitrequest) begin
      for (int i = 0; i < 16; i++)
        ram[i] <= 2'b00;
    end else if (mem_wr_write) begin
      ram[mem_wr_address] <= mem_wr_writedata;
    end
    if (mem_wr_write && mem_wr_address == mem_rd_address)
      mem_rd_readdata <= mem_wr_writedata;
    else
      mem_rd_readdata <= ram[mem_rd_address];
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic step(input logic        rst,
                      input logic        wq,
                      input logic [3:0]  v,
                      input logic [15:0] a,
                      input logic [3:0]  uw,
                      input logic [7:0]  ud,
                      input logic [3:0]  rdy);
    rsp_t       e;
    logic       act;
    logic [3:0] oh;
    int         gi;
    e = '{client: 0, addr: 4'd0, state: 2'd0};
    @(negedge clk);
    reset = rst;
    mem_wr_waitrequest = wq;
    req_valid = v;
    req_address = a;
    upd_write = uw;
    upd_writedata = ud;
    #1;
    chk("req_ready", 32'(req_ready), 32'(rdy));
    chk("rmw_count", 32'(rmw_count), 32'(exp_cnt));
    act = 1'b0;
    if (pend.size() > 0) begin
      e = pend.pop_front();
      act = !rst && !wq;
    end
    oh = act ? (4'b0001 << e.client) : 4'b0000;
    chk("rsp_valid", 32'(rsp_valid), 32'(oh));
    chk("rsp_state", 32'(rsp_state),
        act ? 32'(e.state) : 32'd0);
    chk("mem_wr_write", 32'(mem_wr_write),
        32'(act && uw[e.client]));
    if (act && uw[e.client]) begin
      chk("mem_wr_address", 32'(mem_wr_address),
          32'(e.addr));
      chk("mem_wr_writedata", 32'(mem_wr_writedata),
          32'(ud[e.client*2 +: 2]));
      exp_mem[e.addr] = ud[e.client*2 +: 2];
    end
    if (act && exp_cnt != 16'hFFFF)
      exp_cnt++;
    if (wq)
      for (int i = 0; i < 16; i++) exp_mem[i] = 2'b00;
    if (rst) begin
      exp_cnt = '0;
      pend.delete();
    end
    if (rdy != 4'b0000) begin
      gi = 0;
      for (int i = 0; i < 4; i++)
        if (rdy[i]) gi = i;
      e.client = gi;
      e.addr   = a[gi*4 +: 4];
      e.state  = exp_mem[e.addr];
      pend.push_back(e);
    end
  endtask

  localparam logic [15:0] A1234 = 16'h4321;

  initial begin
    reset = 1'b1;
    mem_wr_waitrequest = 1'b1;
    req_valid = '0;
    req_address = '0;
    upd_write = '0;
    upd_writedata = '0;
    exp_cnt = '0;
    for (int i = 0; i < 16; i++) exp_mem[i] = 2'b00;

    // reset with RAM clearing: no grants, busy
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 4'hF, A1234, 0, 0, 4'b0000);
      chk("busy_rst", 32'(busy), 32'd1);
    end
    chk("rd_addr_rst", 32'(mem_rd_address), 32'd0);
    chk("wr_addr_rst", 32'(mem_wr_address), 32'd0);
    for (int i = 0; i < 2; i++) begin
      step(0, 1, 4'hF, A1234, 0, 0, 4'b0000);
      chk("busy_init", 32'(busy), 32'd1);
    end
    // first low waitrequest: still INIT this cycle
    step(0, 0, 4'hF, A1234, 0, 0, 4'b0000);
    chk("busy_trans", 32'(busy), 32'd1);

    // all valid: grants 0,1,2,3,0 with write-back
    step(0, 0, 4'hF, A1234, 4'hF, 8'hE6, 4'b0001);
    step(0, 0, 4'hF, A1234, 4'hF, 8'hE6, 4'b0010);
    step(0, 0, 4'hF, A1234, 4'hF, 8'hE6, 4'b0100);
    step(0, 0, 4'hF, A1234, 4'hF, 8'hE6, 4'b1000);
    step(0, 0, 4'hF, A1234, 4'hF, 8'hE6, 4'b0001);
    step(0, 0, 4'h0, A1234, 4'hF, 8'hE6, 4'b0000);
    chk("busy_drain", 32'(busy), 32'd1);
    chk("rd_addr_hold", 32'(mem_rd_address), 32'd1);
    step(0, 0, 4'h0, A1234, 0, 0, 4'b0000);
    chk("busy_idle", 32'(busy), 32'd0);

    // write then read same address next cycle
    step(0, 0, 4'b0001, 16'h0005, 0, 0, 4'b0001);
    step(0, 0, 4'b0010, 16'h0050, 4'b0001, 8'h01,
         4'b0010);
    step(0, 0, 4'b0000, 16'h0000, 0, 0, 4'b0000);
    chk("bypass_state", 32'(exp_mem[5]), 32'd1);

    // other client's upd_write is ignored
    step(0, 0, 4'b0100, 16'h0600, 0, 0, 4'b0100);
    step(0, 0, 4'b0000, 16'h0000, 4'b1000, 8'hC0,
         4'b0000);
    step(0, 0, 4'b0000, 16'h0000, 0, 0, 4'b0000);

    // waitrequest during stage 1 aborts
    step(0, 0, 4'b1000, 16'h7000, 0, 0, 4'b1000);
    step(0, 1, 4'b0000, 16'h7000, 4'b1000, 8'h40,
         4'b0000);
    chk("busy_abort", 32'(busy), 32'd1);
    step(0, 1, 4'b1000, 16'h7000, 0, 0, 4'b0000);
    step(0, 0, 4'b1000, 16'h7000, 0, 0, 4'b0000);
    step(0, 0, 4'b1000, 16'h7000, 4'b1000, 8'h80,
         4'b1000);
    step(0, 0, 4'b0000, 16'h0000, 4'b1000, 8'h80,
         4'b0000);

    // reset during stage 1 drops the RMW
    step(0, 0, 4'b0100, 16'h0900, 0, 0, 4'b0100);
    step(1, 0, 4'b0000, 16'h0900, 4'b0100, 8'h30,
         4'b0000);
    step(0, 0, 4'b0001, 16'h0000, 0, 0, 4'b0000);
    chk("busy_after_rst", 32'(busy), 32'd1);

    // run count up to 16'hFFFE, then saturate
    while (int'(exp_cnt) + pend.size() < 32'hFFFE)
      step(0, 0, 4'b0001, 16'h0000, 0, 0, 4'b0001);
    step(0, 0, 4'b0000, 16'h0000, 0, 0, 4'b0000);
    step(0, 0, 4'b0000, 16'h0000, 0, 0, 4'b0000);
    chk("count_fffe", 32'(rmw_count), 32'hFFFE);
    for (int i = 0; i < 3; i++)
      step(0, 0, 4'b0001, 16'h0000, 0, 0, 4'b0001);
    step(0, 0, 4'b0000, 16'h0000, 0, 0, 4'b0000);
    step(0, 0, 4'b0000, 16'h0000, 0, 0, 4'b0000);
    chk("count_sat", 32'(rmw_count), 32'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dfa_state_rmw_arbiter.md
# dfa_state_rmw_arbiter

Round-robin read-modify-write scheduler that shares one DFA state RAM (single write port, single read port, one-cycle registered read with same-cycle write bypass, clear-on-reset with `wr_waitrequest`) between `NUM_CLIENTS` width-adapter channels. Each grant reads a channel's state word, hands it to the owning client, and writes back the client's next-state in the following cycle. Back-to-back RMWs run at one per cycle with no hazard stall. Sits between the per-channel adapter FSM logic and the state RAM instance.

## Interface
- `NUM_CLIENTS`, 4, number of requesters (2..8)
- `ADDRESS_WIDTH`, 4, state RAM address width
- `DATA_WIDTH`, 2, state word width
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `req_valid`  in  NUM_CLIENTS  per-client RMW request
- `req_address`  in  NUM_CLIENTS*ADDRESS_WIDTH  packed per-client state address, client i at bits [i*AW +: AW]
- `req_ready`  out  NUM_CLIENTS  one-hot grant, combinational
- `rsp_valid`  out  NUM_CLIENTS  one-hot: current state presented to client
- `rsp_state`  out  DATA_WIDTH  current state word (shared bus)
- `upd_write`  in  NUM_CLIENTS  client writes next-state in its rsp cycle
- `upd_writedata`  in  NUM_CLIENTS*DATA_WIDTH  packed next-state words
- `mem_rd_address`  out  ADDRESS_WIDTH  to RAM read port
- `mem_rd_readdata`  in  DATA_WIDTH  from RAM, valid cycle after address
- `mem_wr_address`  out  ADDRESS_WIDTH  to RAM write port
- `mem_wr_writedata`  out  DATA_WIDTH  to RAM write port
- `mem_wr_write`  out  1  RAM write strobe
- `mem_wr_waitrequest`  in  1  RAM clearing / not ready
- `busy`  out  1  high in INIT or while stage 1 is occupied
- `rmw_count`  out  16  completed RMWs, saturating at 16'hFFFF

## Operation
- FSM states: INIT, RUN. Reset → INIT. INIT→RUN on first cycle with `mem_wr_waitrequest`=0. RUN→INIT whenever `mem_wr_waitrequest`=1 (RAM re-clearing).
- Arbitration (RUN only, waitrequest low): round-robin over `req_valid`, search starts at `rr_ptr`; winner i gets `req_ready[i]`=1; `rr_ptr` ← i+1 mod NUM_CLIENTS. No winner: `rr_ptr` unchanged.
- Stage 0 (grant cycle n): `mem_rd_address` = winner's address; register `s1_valid`, `s1_client`, `s1_address`. With no grant, `mem_rd_address` holds its last value.
- Stage 1 (cycle n+1): `rsp_valid[s1_client]`=1, `rsp_state`=`mem_rd_readdata`. If `upd_write[s1_client]`: `mem_wr_write`=1, `mem_wr_address`=`s1_address`, `mem_wr_writedata`=client's slice. `upd_write` from any other client ignored. `rmw_count` increments on every stage-1 completion whether or not written back.
- Hazard: grant at n+1 to the same address as stage-1 write at n+1 is resolved by RAM write bypass; no stall, no extra logic.
- Waitrequest rising while `s1_valid`: transaction aborted — `rsp_valid` stays 0, no write, no count increment.
- `rsp_state` is don't-care when `rsp_valid`=0; drive 0.

## Timing
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_state`=0, `mem_wr_write`=0, `mem_rd_address`=0, `mem_wr_address`=0, `mem_wr_writedata`=0, `busy`=1, `rmw_count`=0, `rr_ptr`=0, `s1_valid`=0.
- Request to response latency: 1 cycle. Response to write-back: same cycle. Throughput: 1 RMW/cycle.
- `req_ready` depends combinationally on `req_valid`, FSM state and `mem_wr_waitrequest` only; it never depends on `upd_*`.
- Reset during stage 1 drops the transaction; no write is issued in the reset cycle.

## Structure
- Shared package `dfa_state_pkg`: FSM state enum (INIT, RUN), `RMW_COUNT_WIDTH`=16.
- One sub-module: `rr_arbiter` (parameterised one-hot round-robin arbiter with pointer update), reusable elsewhere.
- Packed-vector slicing and stage-1 mux stay in the top module.

## Test plan
- Reset held 3 cycles, RAM waitrequest high 2 more cycles → `req_ready`=0 throughout, `busy`=1, INIT→RUN on the first low waitrequest cycle.
- All 4 clients valid, distinct addresses 1,2,3,4 → grants 0,1,2,3,0 in consecutive cycles; `rsp_valid` one-hot one cycle after each grant.
- Client 0 RMW addr 5 writes 2'b01, client 1 RMW addr 5 granted next cycle → client 1 sees `rsp_state`=2'b01 (bypass path).
- Client 2 in rsp cycle with `upd_write`=0 while client 3 drives `upd_write`=1 → `mem_wr_write`=0, `rmw_count` +1.
- `mem_wr_waitrequest` pulsed high during stage 1 → no `rsp_valid`, no write, count unchanged, FSM in INIT until low.
- `rmw_count` preloaded to 16'hFFFE by 65534 RMWs, then 3 more → saturates at 16'hFFFF.
